// File: rtl/fifo_nox_rv.sv
// rtl/fifo_nox_rv.sv - ready/valid FIFO, any depth, fall-through head, level flags and high-water mark
module fifo_nox_rv #(
    parameter int SLOTS   = 4,
    parameter int WIDTH   = 8,
    parameter int AF_THR  = 3,
    parameter int AE_THR  = 1,
    parameter bit FULL_RW = 1'b0,
    localparam int CW     = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CW-1:0]    ocup_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [CW-1:0]    hwm_o
);

    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CW-1:0] SLOTS_C = CW'(SLOTS);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THR);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THR);
    localparam logic [PW-1:0] LAST_C  = PW'(SLOTS - 1);

    if (SLOTS < 1) begin : g_bad_slots
        $error("fifo_nox_rv: SLOTS must be >= 1");
    end
    if (AF_THR < 1 || AF_THR > SLOTS) begin : g_bad_af
        $error("fifo_nox_rv: AF_THR must be within 1..SLOTS");
    end
    if (AE_THR < 0 || AE_THR >= SLOTS) begin : g_bad_ae
        $error("fifo_nox_rv: AE_THR must be within 0..SLOTS-1");
    end

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    ocup;
    logic [CW-1:0]    ocup_next;
    logic [CW-1:0]    hwm;
    logic             full;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths never alias into unused slots.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    assign full = (ocup == SLOTS_C);

    // With FULL_RW the write side looks through to out_ready_i when full.
    assign in_ready_o  = !clear_i && (!full || (FULL_RW && out_ready_i));
    assign out_valid_o = !clear_i && (ocup != '0);
    assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        ocup_next = ocup;
        if (push && !pop) begin
            ocup_next = ocup + 1'b1;
        end else if (pop && !push) begin
            ocup_next = ocup - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ocup   <= '0;
            hwm    <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ocup   <= '0;
            hwm    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            ocup <= ocup_next;
            if (ocup_next > hwm) begin
                hwm <= ocup_next;
            end
        end
    end

    assign ocup_o         = ocup;
    assign hwm_o          = hwm;
    assign almost_full_o  = (ocup >= AF_C);
    assign almost_empty_o = (ocup <= AE_C);

endmodule

// File: tb/tb_fifo_nox_rv.sv
// tb/tb_fifo_nox_rv.sv - self-checking bench for fifo_nox_rv with a queue reference model
module tb_fifo_nox_rv;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic       rdy0, vld0, af0, ae0, rdy1, vld1, af1, ae1;
    logic [7:0] dat0, dat1;
    logic [1:0] ocup0, hwm0, ocup1, hwm1;
    logic [15:0] obs0, obs1;

    int tests = 0;
    int fails = 0;

    localparam logic [15:0] RESET_VEC = 16'b1_0_00000000_00_00_0_1;

    always #5 clk = ~clk;

    fifo_nox_rv #(.SLOTS(3), .WIDTH(8), .AF_THR(2), .AE_THR(1), .FULL_RW(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(in_data),
        .out_valid_o(vld0), .out_ready_i(out_ready), .out_data_o(dat0),
        .ocup_o(ocup0), .almost_full_o(af0), .almost_empty_o(ae0), .hwm_o(hwm0)
    );

    fifo_nox_rv #(.SLOTS(3), .WIDTH(8), .AF_THR(2), .AE_THR(1), .FULL_RW(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data),
        .out_valid_o(vld1), .out_ready_i(out_ready), .out_data_o(dat1),
        .ocup_o(ocup1), .almost_full_o(af1), .almost_empty_o(ae1), .hwm_o(hwm1)
    );

    assign obs0 = {rdy0, vld0, dat0, ocup0, hwm0, af0, ae0};
    assign obs1 = {rdy1, vld1, dat1, ocup1, hwm1, af1, ae1};

    // Reference: a 3-deep queue per instance; instance 1 accepts when full if a pop happens too.
    logic [7:0] mq [2][$];
    int         mhwm [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq[0].delete();
            mq[1].delete();
            mhwm[0] = 0;
            mhwm[1] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int sz;
                bit p, o;
                sz = mq[k].size();
                if (clear) begin
                    mq[k].delete();
                    mhwm[k] = 0;
                end else begin
                    p = in_valid && (sz < 3 || (k == 1 && out_ready && sz == 3));
                    o = (sz != 0) && out_ready;
                    if (o) void'(mq[k].pop_front());
                    if (p) mq[k].push_back(in_data);
                    if (mq[k].size() > mhwm[k]) mhwm[k] = mq[k].size();
                end
            end
        end
    end

    function automatic logic [15:0] exp_vec(int k);
        int sz;
        logic rdy, vld;
        logic [7:0] dat;
        sz  = mq[k].size();
        rdy = !clear && (sz < 3 || (k == 1 && out_ready && sz == 3));
        vld = !clear && (sz != 0);
        dat = vld ? mq[k][0] : 8'h00;
        return {rdy, vld, dat, 2'(sz), 2'(mhwm[k]), 1'(sz >= 2), 1'(sz <= 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        tests++; if (obs0 !== RESET_VEC) begin fails++; $display("FAIL reset_dut0: got %h expected %h", obs0, RESET_VEC); end
        tests++; if (obs1 !== RESET_VEC) begin fails++; $display("FAIL reset_dut1: got %h expected %h", obs1, RESET_VEC); end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA1;
        tick();
        in_data = 8'hA2;
        tick();
        #1;
        tests++; if (af0 !== 1'b1) begin fails++; $display("FAIL fill_af: got %b expected 1", af0); end
        tests++; if (ocup0 !== 2'd2) begin fails++; $display("FAIL fill_ocup2: got %0d expected 2", ocup0); end
        in_data = 8'hA3;
        tick();
        #1;
        tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL fill_ready0: got %b expected 0", rdy0); end
        tests++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL fill_ready1: got %b expected 0", rdy1); end
        tests++; if (ocup0 !== 2'd3) begin fails++; $display("FAIL fill_ocup3: got %0d expected 3", ocup0); end
        in_data = 8'hA4;
        tick();
        #1;
        tests++; if (ocup0 !== 2'd3) begin fails++; $display("FAIL fill_held_ocup: got %0d expected 3", ocup0); end
        tests++; if (dat0 !== 8'hA1) begin fails++; $display("FAIL fill_head: got %h expected a1", dat0); end
    endtask

    task automatic test_full_rw();
        in_data = 8'hB4;
        out_ready = 1'b1;
        #1;
        tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL fullrw_ready0: got %b expected 0", rdy0); end
        tests++; if (rdy1 !== 1'b1) begin fails++; $display("FAIL fullrw_ready1: got %b expected 1", rdy1); end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        tests++; if (ocup0 !== 2'd2) begin fails++; $display("FAIL fullrw_ocup0: got %0d expected 2", ocup0); end
        tests++; if (ocup1 !== 2'd3) begin fails++; $display("FAIL fullrw_ocup1: got %0d expected 3", ocup1); end
        tests++; if (dat1 !== 8'hA2) begin fails++; $display("FAIL fullrw_head1: got %h expected a2", dat1); end
        tests++; if (hwm0 !== 2'd3) begin fails++; $display("FAIL fullrw_hwm0: got %0d expected 3", hwm0); end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hCC;
        out_ready = 1'b1;
        #1;
        tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL clear_ready: got %b expected 0", rdy0); end
        tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL clear_valid: got %b expected 0", vld0); end
        tests++; if (dat0 !== 8'h00) begin fails++; $display("FAIL clear_data: got %h expected 00", dat0); end
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        tests++; if ({ocup0, hwm0, vld0, dat0} !== 13'd0) begin fails++; $display("FAIL clear_after0: got ocup %0d hwm %0d valid %b data %h expected all 0", ocup0, hwm0, vld0, dat0); end
        tests++; if ({ocup1, hwm1} !== 4'd0) begin fails++; $display("FAIL clear_after1: got ocup %0d hwm %0d expected 0", ocup1, hwm1); end
    endtask

    task automatic test_latency();
        in_valid = 1'b1;
        in_data = 8'h5A;
        #1;
        tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL lat_same_cycle: got %b expected 0", vld0); end
        tick();
        in_valid = 1'b0;
        #1;
        tests++; if (vld0 !== 1'b1) begin fails++; $display("FAIL lat_valid: got %b expected 1", vld0); end
        tests++; if (dat0 !== 8'h5A) begin fails++; $display("FAIL lat_data: got %h expected 5a", dat0); end
        tests++; if (ocup0 !== 2'd1 || hwm0 !== 2'd1) begin fails++; $display("FAIL lat_level: got ocup %0d hwm %0d expected 1 1", ocup0, hwm0); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL lat_drained: got %b expected 0", vld0); end
    endtask

    task automatic test_stream();
        int sent;
        int cyc;
        bit pushed;
        logic [7:0] got [$];
        sent = 0;
        cyc = 0;
        while (got.size() < 10 && cyc < 200) begin
            @(negedge clk);
            in_valid = (sent < 10);
            in_data = 8'(sent);
            out_ready = (cyc % 2) == 1;
            #1;
            pushed = in_valid && rdy0;
            if (vld0 && out_ready) got.push_back(dat0);
            @(posedge clk);
            if (pushed) sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (got.size() != 10) begin fails++; $display("FAIL stream_count: got %0d expected 10", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            tests++; if (got[i] !== 8'(i)) begin fails++; $display("FAIL stream_order[%0d]: got %h expected %h", i, got[i], 8'(i)); end
        end
        tests++; if (hwm0 !== 2'd3) begin fails++; $display("FAIL stream_hwm: got %0d expected 3", hwm0); end
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            clear = ($urandom_range(31) == 0);
            in_valid = ($urandom_range(3) < ((i / 250) % 2 == 0 ? 3 : 1));
            in_data = 8'($urandom);
            out_ready = ($urandom_range(3) < ((i / 300) % 2 == 0 ? 1 : 3));
            #1;
            tests++; if (obs0 !== exp_vec(0)) begin fails++; $display("FAIL random_dut0 cycle %0d: got %h expected %h", i, obs0, exp_vec(0)); end
            tests++; if (obs1 !== exp_vec(1)) begin fails++; $display("FAIL random_dut1 cycle %0d: got %h expected %h", i, obs1, exp_vec(1)); end
        end
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        #1;
        tests++; if (ocup0 !== 2'd2) begin fails++; $display("FAIL arst_pre_ocup: got %0d expected 2", ocup0); end
        #1 rst = 1'b1;
        #1;
        tests++; if (obs0 !== RESET_VEC) begin fails++; $display("FAIL arst_dut0: got %h expected %h", obs0, RESET_VEC); end
        tests++; if (obs1 !== RESET_VEC) begin fails++; $display("FAIL arst_dut1: got %h expected %h", obs1, RESET_VEC); end
        #1 rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        #1;
        tests++; if (vld0 !== 1'b1 || dat0 !== 8'h77 || ocup0 !== 2'd1) begin fails++; $display("FAIL arst_readback: got valid %b data %h ocup %0d expected 1 77 1", vld0, dat0, ocup0); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rw();
        test_clear();
        test_latency();
        test_stream();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
